// File: rtl/hdmi_frame_rd_ctrl.sv
// hdmi_frame_rd_ctrl: read-side scheduler between the DDR read port and the
// HDMI line FIFO. On each frame start it flushes the FIFO, rewinds to the
// frame base, and issues burst reads (req/ack/done) while the FIFO has room.
// Optional macro FRAME_RD_PINGPONG_EN: selects the base bank from wr_bank,
// sampled at frame start.
module hdmi_frame_rd_ctrl #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned LEN_W       = 9,
  parameter int unsigned FIFO_CNT_W  = 10,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned BURST_LEN   = 128,
  parameter int unsigned FRAME_WORDS = 1024*600/8,
  parameter int unsigned BASE_ADDR0  = 0
`ifdef FRAME_RD_PINGPONG_EN
  ,
  parameter int unsigned BASE_ADDR1  = 'h100000
`endif
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  init_done,
  input  logic                  vs_in,
  input  logic [FIFO_CNT_W-1:0] fifo_wr_cnt,
  output logic                  fifo_clr,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [LEN_W-1:0]      rd_len,
  input  logic                  rd_ack,
  input  logic                  rd_done,
  output logic                  frame_busy,
  output logic                  late_err
`ifdef FRAME_RD_PINGPONG_EN
  ,
  input  logic                  wr_bank
`endif
);

  localparam int unsigned WL_W = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CW   = FIFO_CNT_W + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_VS = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_REQ     = 3'd3;
  localparam logic [2:0] ST_BURST   = 3'd4;

  logic [2:0]        state;
  logic              vs_d;
  logic              fs;
  logic              req_q;
  logic              restart_pend;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base_addr;
  logic [WL_W-1:0]   words_left;
  logic [LEN_W-1:0]  next_len;
  logic              room;
  logic              restart;

`ifdef FRAME_RD_PINGPONG_EN
  logic bank_q;

  // Remember the bank seen at the last frame start for deferred restarts
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      bank_q <= 1'b0;
    else if (fs)
      bank_q <= wr_bank;
  end

  // Bank is taken live on the frame-start cycle, otherwise from the latch
  always_comb begin
    base_addr = ADDR_W'(BASE_ADDR0);
    if (fs ? wr_bank : bank_q)
      base_addr = ADDR_W'(BASE_ADDR1);
  end
`else
  // Single-bank build: the frame always starts at bank 0
  always_comb base_addr = ADDR_W'(BASE_ADDR0);
`endif

  // Frame-start edge, FIFO room test, burst length and restart decision
  always_comb begin
    fs       = vs_in & ~vs_d;
    room     = ({1'b0, fifo_wr_cnt} + CW'(BURST_LEN)) <= CW'(FIFO_DEPTH);
    next_len = LEN_W'(BURST_LEN);
    if (32'(words_left) < BURST_LEN)
      next_len = LEN_W'(words_left);
    restart  = ((state == ST_WAIT_VS) && fs) ||
               ((state == ST_CHECK)   && fs) ||
               ((state == ST_REQ)     && fs && !rd_ack) ||
               ((state == ST_BURST)   && rd_done && (restart_pend || fs));
  end

  // A frame start while a request is still unacknowledged withdraws it in the
  // same cycle; a coincident ack wins and the request stands.
  always_comb rd_req = req_q & ~(fs & ~rd_ack);

  // Frame fetch state machine
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      vs_d         <= 1'b0;
      fifo_clr     <= 1'b0;
      req_q        <= 1'b0;
      rd_addr      <= '0;
      rd_len       <= '0;
      frame_busy   <= 1'b0;
      late_err     <= 1'b0;
      restart_pend <= 1'b0;
      addr         <= '0;
      words_left   <= '0;
    end else begin
      vs_d     <= vs_in;
      fifo_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_done)
            state <= ST_WAIT_VS;
        end
        ST_WAIT_VS: ;
        ST_CHECK: begin
          if (fs) begin
            if (words_left != '0)
              late_err <= 1'b1;
          end else if (words_left == '0) begin
            frame_busy <= 1'b0;
            state      <= ST_WAIT_VS;
          end else if (room) begin
            req_q   <= 1'b1;
            rd_addr <= addr;
            rd_len  <= next_len;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            req_q <= 1'b0;
            state <= ST_BURST;
            if (fs) begin
              restart_pend <= 1'b1;
              late_err     <= 1'b1;
            end
          end else if (fs) begin
            req_q    <= 1'b0;
            late_err <= 1'b1;
          end
        end
        ST_BURST: begin
          if (fs) begin
            restart_pend <= 1'b1;
            late_err     <= 1'b1;
          end
          if (rd_done && !(restart_pend || fs)) begin
            addr       <= addr + ADDR_W'(rd_len);
            words_left <= words_left - WL_W'(rd_len);
            state      <= ST_CHECK;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Frame (re)start overrides whatever the state case decided
      if (restart) begin
        fifo_clr     <= 1'b1;
        addr         <= base_addr;
        words_left   <= WL_W'(FRAME_WORDS);
        frame_busy   <= 1'b1;
        restart_pend <= 1'b0;
        state        <= ST_CHECK;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_frame_rd_ctrl.sv
// Directed bench for hdmi_frame_rd_ctrl (default build, single bank) with a
// 10-word frame, 4-word bursts and a 16-word FIFO.
module tb_hdmi_frame_rd_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_done = 1'b1;
  logic        vs_in = 1'b0;
  logic [9:0]  fifo_wr_cnt = '0;
  logic        fifo_clr;
  logic        rd_req;
  logic [27:0] rd_addr;
  logic [8:0]  rd_len;
  logic        rd_ack = 1'b0;
  logic        rd_done = 1'b0;
  logic        frame_busy;
  logic        late_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  hdmi_frame_rd_ctrl #(
    .ADDR_W(28), .LEN_W(9), .FIFO_CNT_W(10), .FIFO_DEPTH(16),
    .BURST_LEN(4), .FRAME_WORDS(10), .BASE_ADDR0(0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
    .vs_in(vs_in), .fifo_wr_cnt(fifo_wr_cnt), .fifo_clr(fifo_clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .rd_done(rd_done), .frame_busy(frame_busy),
    .late_err(late_err)
  );

  typedef struct {
    logic        vs;
    logic        ack;
    logic        done;
    logic [9:0]  cnt;
    logic        clr;
    logic        req;
    logic [27:0] addr;
    logic [8:0]  len;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {24'd0, fifo_clr, rd_req, rd_addr, rd_len, frame_busy, late_err};
  endfunction

  function automatic logic [63:0] pack(input logic clr, input logic req,
                                       input logic [27:0] a, input logic [8:0] l,
                                       input logic busy, input logic err);
    return {24'd0, clr, req, a, l, busy, err};
  endfunction

  initial begin
    //            vs ack done cnt   clr req addr  len  busy err
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 28'd0, 9'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 28'd0, 9'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 28'd0, 9'd4, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 28'd0, 9'd4, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 28'd0, 9'd4, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 28'd4, 9'd4, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 28'd4, 9'd4, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 28'd4, 9'd4, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 28'd8, 9'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 28'd8, 9'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 28'd8, 9'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 28'd8, 9'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 28'd8, 9'd2, 1'b0, 1'b0};

    // Reset values
    tick();
    tick();
    chk("reset", outs(), pack(0, 0, 0, 0, 0, 0));
    #1 sys_rst = 1'b0;

    // Full frame with immediate ack/done: (0,4) (4,4) (8,2)
    for (int i = 0; i < 13; i++) begin
      vs_in       = tbl[i].vs;
      rd_ack      = tbl[i].ack;
      rd_done     = tbl[i].done;
      fifo_wr_cnt = tbl[i].cnt;
      tick();
      chk($sformatf("frame_row%0d", i), outs(),
          pack(tbl[i].clr, tbl[i].req, tbl[i].addr, tbl[i].len, tbl[i].busy, tbl[i].err));
    end
    rd_ack = 1'b0; rd_done = 1'b0; vs_in = 1'b0;

    // FIFO nearly full: no request at 13, request one cycle after drop to 12
    fifo_wr_cnt = 10'd13;
    vs_in = 1'b1; tick(); vs_in = 1'b0;
    chk("full_clr", {63'd0, fifo_clr}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_noreq", {62'd0, rd_req, fifo_clr}, 64'd0);
    end
    fifo_wr_cnt = 10'd12;
    tick();
    chk("room_req", outs(), pack(0, 1, 0, 4, 1, 0));

    // Request held stable while ack is low
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_req", {27'd0, rd_req, rd_addr, rd_len}, {27'd0, 1'b1, 28'd0, 9'd4});
    end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("ack_drop", {63'd0, rd_req}, 64'd0);

    // Frame start during the second burst defers the restart until rd_done
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    tick();
    chk("burst2_req", outs(), pack(0, 1, 4, 4, 1, 0));
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("burst2_err0", {62'd0, rd_req, late_err}, 64'd0);
    vs_in = 1'b1; tick(); vs_in = 1'b0;
    chk("late_set", {61'd0, fifo_clr, rd_req, late_err}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_noreq", {62'd0, fifo_clr, rd_req}, 64'd0);
    end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("late_clr", {62'd0, fifo_clr, frame_busy}, 64'd3);
    tick();
    chk("late_restart", outs(), pack(0, 1, 0, 4, 1, 1));

    // rd_done outside BURST is ignored
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("stray_done", {27'd0, rd_req, rd_addr, rd_len}, {27'd0, 1'b1, 28'd0, 9'd4});

    // Frame start in REQ without ack withdraws the request immediately
    vs_in = 1'b1; #1;
    chk("req_withdraw", {63'd0, rd_req}, 64'd0);
    tick(); vs_in = 1'b0;
    chk("req_fs_clr", {62'd0, fifo_clr, rd_req}, 64'd2);
    tick();
    chk("req_fs_restart", outs(), pack(0, 1, 0, 4, 1, 1));

    // Ack and frame start together: ack honoured, restart after the burst
    rd_ack = 1'b1; vs_in = 1'b1; #1;
    chk("ack_fs_req", {63'd0, rd_req}, 64'd1);
    tick(); rd_ack = 1'b0; vs_in = 1'b0;
    chk("ack_fs_burst", {62'd0, fifo_clr, rd_req}, 64'd0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("ack_fs_clr", {63'd0, fifo_clr}, 64'd1);
    tick();
    chk("ack_fs_restart", outs(), pack(0, 1, 0, 4, 1, 1));

    // Frame starts ignored until calibration completes
    sys_rst = 1'b1; init_done = 1'b0; fifo_wr_cnt = '0;
    tick(); tick();
    chk("reset2", outs(), pack(0, 0, 0, 0, 0, 0));
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vs_in = 1'b1; tick(); vs_in = 1'b0; tick();
      chk("nocal", {62'd0, fifo_clr, rd_req}, 64'd0);
      tick();
      chk("nocal2", {62'd0, fifo_clr, rd_req}, 64'd0);
    end
    init_done = 1'b1; tick();
    vs_in = 1'b1; tick(); vs_in = 1'b0;
    chk("cal_clr", outs(), pack(1, 0, 0, 0, 1, 0));
    tick();
    chk("cal_req", outs(), pack(0, 1, 0, 4, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
